flash_cmd_seq: RTL
==================

// Module: flash_cmd_seq
// PURPOSE
// - Sequences one SPI flash transaction through the byte-level SPI driver: opcode, optional 24-bit address, dummy bytes, then write or read data.
// - Generates the driver baud_en tick, holds the driver's tx_en/tx_cmd/tx_data handshake, and marks the final byte so CS_n releases.
// - Sits between the flash command layer and the SPI byte driver inside flash_top.
// PARAMETERS
// - U_DLY    1   simulation delay applied to every register assignment
// - BAUD_DIV 4   clk_sys cycles per baud_en tick (>=2); the tick is a 1-cycle pulse
// - CS_GAP   4   minimum idle baud ticks after a transaction before the next cmd_ack
// PORTS
// - clk_sys        in  1   system clock
// - rst_n          in  1   asynchronous active-low reset
// - cmd_req        in  1   transaction request; level, sampled in IDLE only
// - cmd_opcode     in  8   flash opcode
// - cmd_addr_en    in  1   1: send cmd_addr as 3 bytes, MSB first
// - cmd_addr       in  24  flash address
// - cmd_dummy      in  4   dummy bytes (0x00, write direction) after the address
// - cmd_rd         in  1   data phase direction: 1 read, 0 write
// - cmd_len        in  9   data bytes, 0..256
// - cmd_ack        out 1   1-cycle pulse: command fields latched
// - cmd_done       out 1   1-cycle pulse: last byte finished, CS_n high
// - cmd_busy       out 1   high from cmd_ack until CS_GAP expires
// - wr_data_req    out 1   1-cycle pulse: next write byte needed
// - wr_data        in  8   write byte, valid with wr_data_vld
// - wr_data_vld    in  1   write byte strobe, accepted only after wr_data_req
// - rd_data        out 8   read byte
// - rd_data_vld    out 1   1-cycle strobe per read data byte
// - baud_en        out 1   driver baud tick
// - drv_tx_en      out 1   1-cycle byte start pulse to the driver
// - drv_tx_cmd     out 4   bit0 read, bit1 last byte, bits 3:2 = 0; held until the next drv_tx_en
// - drv_tx_data    out 8   byte to transmit; held with drv_tx_cmd
// - drv_tx_busy    in  1   driver busy
// - drv_rx_data    in  8   driver received byte
// - drv_rx_valid   in  1   driver received-byte strobe
// BEHAVIOUR
// - Reset: all outputs 0, drv_tx_cmd = 4'h0, state IDLE, baud counter 0.
// - baud_en: free-running modulo-BAUD_DIV counter; pulses when count = BAUD_DIV-1.
// - Phase FSM: IDLE -> OPC -> ADDR (3 bytes, if cmd_addr_en) -> DUMMY (cmd_dummy bytes, skipped if 0) -> DATA (cmd_len bytes, skipped if 0) -> GAP -> IDLE.
// - IDLE with cmd_req=1: latch all cmd_* fields, pulse cmd_ack, enter OPC. cmd_* changes after cmd_ack are ignored.
// - Per-byte sub-FSM: ISSUE -> WAIT_HI -> WAIT_LO.
//   - ISSUE: load drv_tx_data/drv_tx_cmd, pulse drv_tx_en.
//   - WAIT_HI: wait for drv_tx_busy=1. WAIT_LO: wait for drv_tx_busy=0, then advance.
//   - drv_tx_cmd and drv_tx_data stay stable from ISSUE through WAIT_LO.
// - Last-byte flag, drv_tx_cmd[1]: set on the final byte of the sequence only.
//   - Final byte = last DATA byte; if cmd_len=0, the last DUMMY byte; otherwise the last ADDR byte; otherwise OPC.
// - drv_tx_cmd[0]=1 only for DATA bytes with cmd_rd=1; drv_tx_data = 0x00 for those bytes.
// - Write DATA byte:
//   - Pulse wr_data_req on entry to ISSUE, then wait for wr_data_vld.
//   - CS_n stays asserted while waiting (no last flag yet), so the stall is unbounded.
//   - wr_data_vld while no request is outstanding is ignored.
// - Read DATA: every drv_rx_valid during DATA forwards drv_rx_data to rd_data; rd_data_vld follows one cycle later. Exactly cmd_len strobes per transaction.
// - Byte counter is 9 bits; cmd_len=256 sends 256 bytes. The counter does not wrap past the final byte.
// - After the final WAIT_LO: pulse cmd_done, enter GAP, count CS_GAP baud ticks, then IDLE. cmd_busy drops on the same cycle IDLE is entered.
// - cmd_req held high through GAP: ack is issued on the first IDLE cycle after the gap.
// - Reset mid-transaction: immediate return to IDLE. The driver resets with the same rst_n, so CS_n releases.
// STRUCTURE
// - Shared package flash_pkg: phase state encodings, sub-FSM encodings, the 3-byte address count, and the driver tx_cmd bit positions (RD=0, LAST=1).
// - One sub-module, spi_baud_gen (BAUD_DIV counter -> baud_en). Phase and byte FSMs stay in flash_cmd_seq.
// TESTING
// - Bench pairs flash_cmd_seq with spi_drv and a SPI flash slave model.
// - Opcode 0x06, addr_en=0, len=0 -> one byte, last flag set, cmd_done once, CS_n low for that byte only.
// - Read 0x03, addr 0x123456, len=4, slave returns A0..A3 -> MOSI 03 12 34 56; rd_data A0,A1,A2,A3; last flag on the 8th byte only.
// - Page program 0x02, len=256, wr_data_vld delayed 50 cycles on byte 10 -> CS_n stays low through the stall; 260 bytes total; len counter correct at 256.
// - Fast read 0x0B with dummy=1, len=2 -> byte 5 = 0x00 with write direction; only 2 rd_data_vld.
// - Back-to-back cmd_req held high -> second cmd_ack no earlier than CS_GAP*BAUD_DIV cycles after cmd_done.
// - rst_n asserted during ADDR byte 2 -> all outputs 0 next cycle, CS_n high; a following cmd_req completes normally.

Source files
------------

// File: rtl/flash_cmd_seq_pkg.sv
// ----------------------------------------------------------------------------
// flash_pkg
// Shared definitions for the SPI flash command sequencer:
//   - phase_t   : transaction phase encodings
//   - sub_t     : per-byte handshake encodings
//   - ADDR_BYTES: number of address bytes sent when the address is enabled
//   - TXC_RD / TXC_LAST : bit positions inside the driver tx_cmd nibble
//   - addr_byte : selects one address byte, MSB first
// ----------------------------------------------------------------------------
package flash_pkg;

    typedef enum logic [2:0] {
        PH_IDLE,
        PH_OPC,
        PH_ADDR,
        PH_DUMMY,
        PH_DATA,
        PH_GAP
    } phase_t;

    typedef enum logic [1:0] {
        SB_ISSUE,
        SB_WR_WAIT,
        SB_WAIT_HI,
        SB_WAIT_LO
    } sub_t;

    localparam logic [8:0] ADDR_BYTES = 9'd3;

    localparam int unsigned TXC_RD   = 0;
    localparam int unsigned TXC_LAST = 1;

    function automatic logic [7:0] addr_byte(input logic [23:0] addr, input logic [1:0] idx);
        case (idx)
            2'd0:    return addr[23:16];
            2'd1:    return addr[15:8];
            default: return addr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/flash_cmd_seq_if.sv
// ----------------------------------------------------------------------------
// flash_cmd_seq_if
// Byte-level handshake between the command sequencer and the SPI byte driver.
//   baud_en      seq -> drv  baud tick
//   drv_tx_en    seq -> drv  1-cycle byte start
//   drv_tx_cmd   seq -> drv  bit0 read, bit1 last byte
//   drv_tx_data  seq -> drv  byte to transmit
//   drv_tx_busy  drv -> seq  driver busy
//   drv_rx_data  drv -> seq  received byte
//   drv_rx_valid drv -> seq  received-byte strobe
// master = sequencer side, slave = driver side.
// ----------------------------------------------------------------------------
interface flash_cmd_seq_if;

    logic       baud_en;
    logic       drv_tx_en;
    logic [3:0] drv_tx_cmd;
    logic [7:0] drv_tx_data;
    logic       drv_tx_busy;
    logic [7:0] drv_rx_data;
    logic       drv_rx_valid;

    modport master (
        output baud_en, drv_tx_en, drv_tx_cmd, drv_tx_data,
        input  drv_tx_busy, drv_rx_data, drv_rx_valid
    );

    modport slave (
        input  baud_en, drv_tx_en, drv_tx_cmd, drv_tx_data,
        output drv_tx_busy, drv_rx_data, drv_rx_valid
    );

endinterface

// File: rtl/flash_cmd_seq_baud_gen.sv
// ----------------------------------------------------------------------------
// spi_baud_gen
// Free-running modulo-BAUD_DIV counter; o_baud_en pulses for one cycle when
// the count reaches BAUD_DIV-1.
//   clk_sys   in  system clock
//   rst_n     in  asynchronous active-low reset
//   o_baud_en out baud tick
// ----------------------------------------------------------------------------
module spi_baud_gen #(
    parameter int unsigned BAUD_DIV = 4
) (
    input  logic clk_sys,
    input  logic rst_n,
    output logic o_baud_en
);

    localparam int unsigned     CW   = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

    assign o_baud_en = (r_cnt == LAST);

endmodule

// File: rtl/flash_cmd_seq.sv
// ----------------------------------------------------------------------------
// flash_cmd_seq
// Sequences one SPI flash transaction through the byte driver:
// opcode, optional 3-byte address, dummy bytes, then read or write data.
//   clk_sys, rst_n             clock, async active-low reset
//   cmd_req / cmd_*            command request and fields (latched on cmd_ack)
//   cmd_ack, cmd_done          1-cycle pulses: fields latched / CS_n released
//   cmd_busy                   high from cmd_ack until the CS gap expires
//   wr_data_req/wr_data/_vld   write-data handshake, one byte per request
//   rd_data, rd_data_vld       read data forwarded from the driver
//   drv                        byte driver handshake (flash_cmd_seq_if.master)
// ----------------------------------------------------------------------------
module flash_cmd_seq
    import flash_pkg::*;
#(
    parameter int unsigned U_DLY    = 1,
    parameter int unsigned BAUD_DIV = 4,
    parameter int unsigned CS_GAP   = 4
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        cmd_req,
    input  logic [7:0]  cmd_opcode,
    input  logic        cmd_addr_en,
    input  logic [23:0] cmd_addr,
    input  logic [3:0]  cmd_dummy,
    input  logic        cmd_rd,
    input  logic [8:0]  cmd_len,
    output logic        cmd_ack,
    output logic        cmd_done,
    output logic        cmd_busy,
    output logic        wr_data_req,
    input  logic [7:0]  wr_data,
    input  logic        wr_data_vld,
    output logic [7:0]  rd_data,
    output logic        rd_data_vld,
    flash_cmd_seq_if.master drv
);

    localparam int unsigned   GW       = (CS_GAP < 1) ? 1 : $clog2(CS_GAP + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(CS_GAP);

    // Register delay is a simulation-only notion; kept as a parameter for
    // instantiation compatibility.
    logic [31:0] w_unused_dly;
    assign w_unused_dly = U_DLY;

    logic w_baud;

    spi_baud_gen #(.BAUD_DIV(BAUD_DIV)) u_baud (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .o_baud_en (w_baud)
    );

    phase_t         r_phase, w_phase_nx;
    sub_t           r_sub,   w_sub_nx;
    logic [8:0]     r_cnt,   w_cnt_nx;
    logic [GW-1:0]  r_gap,   w_gap_nx;

    logic [7:0]  r_opc;
    logic        r_addr_en;
    logic [23:0] r_addr;
    logic [3:0]  r_dummy;
    logic        r_rd;
    logic [8:0]  r_len;

    logic        r_ack, r_done, r_busy, r_wr_req, r_tx_en, r_rd_vld;
    logic [3:0]  r_tx_cmd;
    logic [7:0]  r_tx_data, r_rd_data;

    logic        w_ack, w_done, w_wr_req, w_issue;
    logic        w_phase_end, w_final, w_wr_byte, w_data_rd, w_tail_empty;
    logic [8:0]  w_dummy9;
    logic [7:0]  w_tx_byte;
    logic [3:0]  w_tx_cmd;

    // Byte position decode: end of current phase and end of whole sequence.
    always_comb begin
        w_dummy9     = {5'd0, r_dummy};
        w_tail_empty = (r_dummy == 4'd0) && (r_len == 9'd0);
        w_wr_byte    = (r_phase == PH_DATA) && !r_rd;
        w_data_rd    = (r_phase == PH_DATA) && r_rd;
        w_phase_end  = 1'b0;
        w_final      = 1'b0;
        w_tx_byte    = 8'h00;
        case (r_phase)
            PH_OPC: begin
                w_phase_end = 1'b1;
                w_final     = !r_addr_en && w_tail_empty;
                w_tx_byte   = r_opc;
            end
            PH_ADDR: begin
                w_phase_end = (r_cnt == ADDR_BYTES - 9'd1);
                w_final     = w_phase_end && w_tail_empty;
                w_tx_byte   = addr_byte(r_addr, r_cnt[1:0]);
            end
            PH_DUMMY: begin
                w_phase_end = (r_cnt == w_dummy9 - 9'd1);
                w_final     = w_phase_end && (r_len == 9'd0);
            end
            PH_DATA: begin
                w_phase_end = (r_cnt == r_len - 9'd1);
                w_final     = w_phase_end;
                w_tx_byte   = r_rd ? 8'h00 : wr_data;
            end
            default: ;
        endcase
        w_tx_cmd           = '0;
        w_tx_cmd[TXC_RD]   = w_data_rd;
        w_tx_cmd[TXC_LAST] = w_final;
    end

    // Next-state logic for phase and per-byte handshake.
    always_comb begin
        w_phase_nx = r_phase;
        w_sub_nx   = r_sub;
        w_cnt_nx   = r_cnt;
        w_gap_nx   = r_gap;
        w_ack      = 1'b0;
        w_done     = 1'b0;
        w_wr_req   = 1'b0;
        w_issue    = 1'b0;
        case (r_phase)
            PH_IDLE: begin
                if (cmd_req) begin
                    w_ack      = 1'b1;
                    w_phase_nx = PH_OPC;
                    w_sub_nx   = SB_ISSUE;
                    w_cnt_nx   = '0;
                end
            end
            PH_GAP: begin
                // Counts CS_GAP+1 ticks so at least CS_GAP full baud periods
                // elapse regardless of tick alignment when the gap starts.
                if (w_baud) begin
                    if (r_gap == GAP_LAST)
                        w_phase_nx = PH_IDLE;
                    else
                        w_gap_nx = r_gap + GW'(1);
                end
            end
            PH_OPC, PH_ADDR, PH_DUMMY, PH_DATA: begin
                case (r_sub)
                    SB_ISSUE: begin
                        if (w_wr_byte) begin
                            w_wr_req = 1'b1;
                            w_sub_nx = SB_WR_WAIT;
                        end else begin
                            w_issue  = 1'b1;
                            w_sub_nx = SB_WAIT_HI;
                        end
                    end
                    SB_WR_WAIT: begin
                        if (wr_data_vld) begin
                            w_issue  = 1'b1;
                            w_sub_nx = SB_WAIT_HI;
                        end
                    end
                    SB_WAIT_HI: begin
                        if (drv.drv_tx_busy)
                            w_sub_nx = SB_WAIT_LO;
                    end
                    SB_WAIT_LO: begin
                        if (!drv.drv_tx_busy) begin
                            w_sub_nx = SB_ISSUE;
                            if (w_final) begin
                                w_done     = 1'b1;
                                w_phase_nx = PH_GAP;
                                w_gap_nx   = '0;
                                w_cnt_nx   = '0;
                            end else if (w_phase_end) begin
                                w_cnt_nx = '0;
                                if (r_phase == PH_OPC && r_addr_en)
                                    w_phase_nx = PH_ADDR;
                                else if (r_phase != PH_DUMMY && r_dummy != 4'd0)
                                    w_phase_nx = PH_DUMMY;
                                else
                                    w_phase_nx = PH_DATA;
                            end else begin
                                w_cnt_nx = r_cnt + 9'd1;
                            end
                        end
                    end
                    default: w_sub_nx = SB_ISSUE;
                endcase
            end
            default: w_phase_nx = PH_IDLE;
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_phase <= PH_IDLE;
            r_sub   <= SB_ISSUE;
            r_cnt   <= '0;
            r_gap   <= '0;
        end else begin
            r_phase <= w_phase_nx;
            r_sub   <= w_sub_nx;
            r_cnt   <= w_cnt_nx;
            r_gap   <= w_gap_nx;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_opc     <= '0;
            r_addr_en <= 1'b0;
            r_addr    <= '0;
            r_dummy   <= '0;
            r_rd      <= 1'b0;
            r_len     <= '0;
            r_ack     <= 1'b0;
            r_done    <= 1'b0;
            r_busy    <= 1'b0;
            r_wr_req  <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_cmd  <= '0;
            r_tx_data <= '0;
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_ack    <= w_ack;
            r_done   <= w_done;
            r_wr_req <= w_wr_req;
            r_tx_en  <= w_issue;
            r_busy   <= (w_phase_nx != PH_IDLE);
            if (w_ack) begin
                r_opc     <= cmd_opcode;
                r_addr_en <= cmd_addr_en;
                r_addr    <= cmd_addr;
                r_dummy   <= cmd_dummy;
                r_rd      <= cmd_rd;
                r_len     <= cmd_len;
            end
            if (w_issue) begin
                r_tx_data <= w_tx_byte;
                r_tx_cmd  <= w_tx_cmd;
            end
            r_rd_vld <= 1'b0;
            if (w_data_rd && drv.drv_rx_valid) begin
                r_rd_vld  <= 1'b1;
                r_rd_data <= drv.drv_rx_data;
            end
        end
    end

    assign cmd_ack          = r_ack;
    assign cmd_done         = r_done;
    assign cmd_busy         = r_busy;
    assign wr_data_req      = r_wr_req;
    assign rd_data          = r_rd_data;
    assign rd_data_vld      = r_rd_vld;
    assign drv.baud_en      = w_baud;
    assign drv.drv_tx_en    = r_tx_en;
    assign drv.drv_tx_cmd   = r_tx_cmd;
    assign drv.drv_tx_data  = r_tx_data;

endmodule
